ahb_pixel_master: RTL and testbench
===================================

Name: ahb_pixel_master

Overview:
- Bus initiator inside the edge-detection ASIC; the image-memory testbench acts as the responder on the other end of this bus.
- Fetches source pixels in sliding-window order (window-by-window, row-major inside each window) and streams them to the window/filter datapath.
- Collects filtered result pixels in a small FIFO and writes them back to sequential output addresses.
- Writes take priority over reads.

Parameters:
- IMG_WIDTH, 602, input image width in pixels.
- IMG_HEIGHT, 602, input image height in pixels.
- WIN_WIDTH, 5, window width; must satisfy (IMG_WIDTH-2) mod (WIN_WIDTH-2) = 0.
- WIN_HEIGHT, 5, window height; must satisfy (IMG_HEIGHT-2) mod (WIN_HEIGHT-2) = 0.
- RD_BASE, 138, byte address of input pixel 0; must be non-zero.
- WR_BASE, 32'h0010_0000, byte address of output pixel 0; must be non-zero.
- BPP, 3, bytes per pixel (address stride).
- FIFO_DEPTH, 4, result FIFO entries; power of 2.

Ports:
- clk, in, 1, system clock; all state updates on the rising edge.
- n_rst, in, 1, reset; asynchronous, active-low.
- start, in, 1, one-cycle pulse that begins a frame; ignored unless in IDLE.
- hrdata, in, 32, read data; [23:0] = {R,G,B}.
- hready, in, 1, responder done: read data valid / write accepted.
- haddr, out, 32, byte address; 0 = no read request.
- hwrite, out, 1, write request.
- hwdata, out, 32, write data {8'h00, R, G, B}.
- pix_out, out, 24, fetched pixel to the datapath.
- pix_valid, out, 1, one-cycle strobe for pix_out.
- win_last, out, 1, coincident with pix_valid on the last pixel of a window.
- res_in, in, 24, result pixel from the datapath.
- res_valid, in, 1, result push.
- res_ready, out, 1, FIFO not full.
- busy, out, 1, high from start until DONE.
- done, out, 1, held high in DONE until the next start.
- err, out, 1, timeout flag (optional feature).

Behaviour:
- Reset values: haddr=0, hwrite=0, hwdata=0, pix_out=0, pix_valid=0, win_last=0, res_ready=1, busy=0, done=0, err=0. Counters i, j, k, n, out_cnt and the FIFO are cleared. Reset mid-frame aborts immediately; no bus cycle completes.
- FSM states: IDLE, ARB, READ, WRITE, DONE.
  - IDLE -> ARB on start. Counters are cleared and done is cleared.
  - ARB selects the next bus cycle:
    - FIFO non-empty -> WRITE.
    - Else reads remaining -> READ.
    - Else out_cnt == (IMG_WIDTH-2)*(IMG_HEIGHT-2) -> DONE.
    - Else stay in ARB and wait for results.
  - READ: haddr = RD_BASE + BPP*(n + k*IMG_WIDTH + j*(WIN_WIDTH-2) + i*(WIN_HEIGHT-2)*IMG_WIDTH), hwrite=0. Held stable until hready is sampled 1. On that edge:
    - pix_out <= hrdata[23:0], pix_valid pulses the next cycle.
    - Counters advance n -> k -> j -> i.
    - haddr returns to 0; next state ARB.
  - WRITE: haddr = WR_BASE + BPP*out_cnt, hwrite=1, hwdata = FIFO head. Held until hready is sampled 1. On that edge: pop FIFO, out_cnt += 1, hwrite <= 0, next state ARB.
  - DONE: busy=0, done=1. start -> ARB, clearing counters and done.
- Minimum spacing is 1 idle (ARB) cycle between bus cycles; hready high in ARB/IDLE is ignored.
- Read counts: WIN_WIDTH*WIN_HEIGHT reads per window; ((IMG_WIDTH-2)/(WIN_WIDTH-2))*((IMG_HEIGHT-2)/(WIN_HEIGHT-2)) windows.
- FIFO:
  - Push when res_valid && res_ready; res_valid while full is dropped, and the datapath must not do this.
  - Simultaneous push and pop while full is legal; res_ready is combinational !full | pop.
- Address arithmetic is 32-bit unsigned, no wrap checks.

Optional Feature:
- Macro: AHB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter runs in READ/WRITE and is cleared on each ARB entry.
  - When it reaches 16'hFFFF without hready: err <= 1, bus outputs return to idle, state goes to DONE.
  - err clears on start.
- When undefined: err is tied 0 and the master waits indefinitely.

Test Plan:
- IMG 8x8, WIN 5x5, hready 1 cycle after each request, no results -> 100 reads (4 windows x 25). First haddr=138, second 141, sixth 138+3*8=162; first addr of window j=1 is 138+9=147. win_last pulses 4 times.
- Same config, datapath pushes a result after each window's reads -> writes to WR_BASE, WR_BASE+3, ...; every write occurs before the next read. done after out_cnt=36.
- Push 5 results back-to-back with FIFO_DEPTH=4 and hready held low -> res_ready=0 after the 4th push with no pop.
- Hold hready low 10 cycles during READ -> haddr stable for all 10 cycles; exactly one pix_valid.
- Assert n_rst=0 mid-WRITE -> hwrite=0, haddr=0, busy=0 asynchronously; a new start restarts at haddr=138.
- AHB_TIMEOUT_EN defined, never assert hready -> err=1 and done=1 after 65535 cycles in READ.

Source files
------------

// File: rtl/ahb_pixel_master.sv
// AHB-style pixel master: fetches source pixels in sliding-window order and writes filtered results back.
// Optional read/write timeout is enabled by defining AHB_TIMEOUT_EN.
module ahb_pixel_master #(
    parameter int unsigned IMG_WIDTH  = 602,
    parameter int unsigned IMG_HEIGHT = 602,
    parameter int unsigned WIN_WIDTH  = 5,
    parameter int unsigned WIN_HEIGHT = 5,
    parameter logic [31:0] RD_BASE    = 32'd138,
    parameter logic [31:0] WR_BASE    = 32'h0010_0000,
    parameter int unsigned BPP        = 3,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic        start,
    input  logic [31:0] hrdata,
    input  logic        hready,
    output logic [31:0] haddr,
    output logic        hwrite,
    output logic [31:0] hwdata,
    output logic [23:0] pix_out,
    output logic        pix_valid,
    output logic        win_last,
    input  logic [23:0] res_in,
    input  logic        res_valid,
    output logic        res_ready,
    output logic        busy,
    output logic        done,
    output logic        err
);
    localparam int unsigned NWX       = (IMG_WIDTH - 2) / (WIN_WIDTH - 2);
    localparam int unsigned NWY       = (IMG_HEIGHT - 2) / (WIN_HEIGHT - 2);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] TOTAL_OUT = 32'((IMG_WIDTH - 2) * (IMG_HEIGHT - 2));
    localparam logic [31:0] IW32      = 32'(IMG_WIDTH);
    localparam logic [31:0] STEP_X    = 32'(WIN_WIDTH - 2);
    localparam logic [31:0] STEP_Y    = 32'((WIN_HEIGHT - 2) * IMG_WIDTH);
    localparam logic [31:0] BPP32     = 32'(BPP);
    localparam logic [15:0] N_MAX     = 16'(WIN_WIDTH - 1);
    localparam logic [15:0] K_MAX     = 16'(WIN_HEIGHT - 1);
    localparam logic [15:0] J_MAX     = 16'(NWX - 1);
    localparam logic [15:0] I_MAX     = 16'(NWY - 1);

    typedef enum logic [2:0] {ST_IDLE, ST_ARB, ST_READ, ST_WRITE, ST_DONE} state_t;
    typedef logic [AW:0] ptr_t;

    state_t      state_r, state_nx_s;
    logic [15:0] n_r, k_r, j_r, i_r;
    logic        rd_left_r;
    logic [31:0] out_cnt_r;
    logic [31:0] haddr_r, hwdata_r;
    logic        hwrite_r, pix_valid_r, win_last_r, busy_r, done_r, err_r;
    logic [23:0] pix_out_r;
    logic [23:0] fifo_mem_r [FIFO_DEPTH];
    ptr_t        wr_ptr_r, rd_ptr_r;
    logic        fifo_empty_s, fifo_full_s, push_s, pop_s, timeout_s;
    logic        win_end_s, rd_last_s;
    logic [31:0] rd_addr_s;
    logic        unused_s;

    assign unused_s     = ^hrdata[31:24];
    assign fifo_empty_s = (wr_ptr_r == rd_ptr_r);
    assign fifo_full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign pop_s        = (state_r == ST_WRITE) && hready;
    assign res_ready    = !fifo_full_s || pop_s;
    assign push_s       = res_valid && res_ready;
    assign win_end_s    = (n_r == N_MAX) && (k_r == K_MAX);
    assign rd_last_s    = win_end_s && (j_r == J_MAX) && (i_r == I_MAX);
    assign rd_addr_s    = RD_BASE + BPP32 * (32'(n_r) + 32'(k_r) * IW32 + 32'(j_r) * STEP_X + 32'(i_r) * STEP_Y);

`ifdef AHB_TIMEOUT_EN
    logic [15:0] to_cnt_r;
    assign timeout_s = ((state_r == ST_READ) || (state_r == ST_WRITE)) && !hready && (to_cnt_r == 16'hFFFF);

    // Bus-cycle watchdog; sits at zero whenever no bus cycle is in flight.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt_r <= 16'd0;
        end else if ((state_r == ST_READ) || (state_r == ST_WRITE)) begin
            to_cnt_r <= to_cnt_r + 16'd1;
        end else begin
            to_cnt_r <= 16'd0;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state_r <= ST_IDLE;
        else        state_r <= state_nx_s;
    end

    // Next-state selection; pending writes always win arbitration.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE:  if (start) state_nx_s = ST_ARB; else state_nx_s = ST_IDLE;
            ST_ARB: begin
                if (!fifo_empty_s)             state_nx_s = ST_WRITE;
                else if (rd_left_r)            state_nx_s = ST_READ;
                else if (out_cnt_r == TOTAL_OUT) state_nx_s = ST_DONE;
                else                           state_nx_s = ST_ARB;
            end
            ST_READ, ST_WRITE: begin
                if (timeout_s)   state_nx_s = ST_DONE;
                else if (hready) state_nx_s = ST_ARB;
                else             state_nx_s = state_r;
            end
            ST_DONE:  if (start) state_nx_s = ST_ARB; else state_nx_s = ST_DONE;
            default:  state_nx_s = ST_IDLE;
        endcase
    end

    // Bus outputs and the pixel strobe toward the datapath.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            haddr_r     <= 32'd0;
            hwrite_r    <= 1'b0;
            hwdata_r    <= 32'd0;
            pix_out_r   <= 24'd0;
            pix_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
        end else begin
            pix_valid_r <= 1'b0;
            win_last_r  <= 1'b0;
            case (state_r)
                ST_ARB: begin
                    if (state_nx_s == ST_WRITE) begin
                        haddr_r  <= WR_BASE + BPP32 * out_cnt_r;
                        hwrite_r <= 1'b1;
                        hwdata_r <= {8'h00, fifo_mem_r[rd_ptr_r[AW-1:0]]};
                    end else if (state_nx_s == ST_READ) begin
                        haddr_r  <= rd_addr_s;
                        hwrite_r <= 1'b0;
                    end
                end
                ST_READ: begin
                    if (timeout_s) begin
                        haddr_r <= 32'd0;
                    end else if (hready) begin
                        haddr_r     <= 32'd0;
                        pix_out_r   <= hrdata[23:0];
                        pix_valid_r <= 1'b1;
                        win_last_r  <= win_end_s;
                    end
                end
                ST_WRITE: begin
                    if (timeout_s || hready) begin
                        haddr_r  <= 32'd0;
                        hwrite_r <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Window traversal counters: column n, row k, window column j, window row i.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            n_r <= 16'd0; k_r <= 16'd0; j_r <= 16'd0; i_r <= 16'd0;
            rd_left_r <= 1'b0;
        end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start) begin
            n_r <= 16'd0; k_r <= 16'd0; j_r <= 16'd0; i_r <= 16'd0;
            rd_left_r <= 1'b1;
        end else if ((state_r == ST_READ) && hready) begin
            if (rd_last_s) rd_left_r <= 1'b0;
            if (n_r != N_MAX) begin
                n_r <= n_r + 16'd1;
            end else begin
                n_r <= 16'd0;
                if (k_r != K_MAX) begin
                    k_r <= k_r + 16'd1;
                end else begin
                    k_r <= 16'd0;
                    if (j_r != J_MAX) begin
                        j_r <= j_r + 16'd1;
                    end else begin
                        j_r <= 16'd0;
                        i_r <= (i_r != I_MAX) ? i_r + 16'd1 : 16'd0;
                    end
                end
            end
        end
    end

    // Frame status and output pixel count.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_cnt_r <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        out_cnt_r <= 32'd0;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        err_r     <= 1'b0;
                    end
                end
                ST_ARB: begin
                    if (state_nx_s == ST_DONE) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                ST_READ, ST_WRITE: begin
                    if (timeout_s) begin
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        err_r  <= 1'b1;
                    end else if (hready && (state_r == ST_WRITE)) begin
                        out_cnt_r <= out_cnt_r + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Result FIFO pointers.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= ptr_t'(0);
            rd_ptr_r <= ptr_t'(0);
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + ptr_t'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + ptr_t'(1);
        end
    end

    // Result FIFO storage.
    always_ff @(posedge clk) begin
        if (push_s) fifo_mem_r[wr_ptr_r[AW-1:0]] <= res_in;
    end

    assign haddr     = haddr_r;
    assign hwrite    = hwrite_r;
    assign hwdata    = hwdata_r;
    assign pix_out   = pix_out_r;
    assign pix_valid = pix_valid_r;
    assign win_last  = win_last_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
endmodule

// File: tb/tb_ahb_pixel_master.sv
// Scoreboard bench for ahb_pixel_master on an 8x8 image with 5x5 windows; the memory
// responder and datapath are modelled here and expected traffic comes from image geometry.
module tb_ahb_pixel_master;
    localparam int          IW   = 8;
    localparam int          IH   = 8;
    localparam int          WW   = 5;
    localparam int          WH   = 5;
    localparam logic [31:0] RDB  = 32'd138;
    localparam logic [31:0] WRB  = 32'h0010_0000;
    localparam int          BPPB = 3;
    localparam int          NOUT = (IW - 2) * (IH - 2);
    localparam int          NWIN = ((IW - 2) / (WW - 2)) * ((IH - 2) / (WH - 2));

    logic        tb_clk, n_rst, start, hready, hwrite, pix_valid, win_last, res_valid, res_ready, busy, done, err;
    logic [31:0] hrdata, haddr, hwdata;
    logic [23:0] pix_out, res_in;

    ahb_pixel_master #(.IMG_WIDTH(IW), .IMG_HEIGHT(IH), .WIN_WIDTH(WW), .WIN_HEIGHT(WH),
                       .RD_BASE(RDB), .WR_BASE(WRB), .BPP(BPPB), .FIFO_DEPTH(4)) dut (
        .clk(tb_clk), .n_rst(n_rst), .start(start), .hrdata(hrdata), .hready(hready),
        .haddr(haddr), .hwrite(hwrite), .hwdata(hwdata), .pix_out(pix_out),
        .pix_valid(pix_valid), .win_last(win_last), .res_in(res_in), .res_valid(res_valid),
        .res_ready(res_ready), .busy(busy), .done(done), .err(err));

    initial tb_clk = 1'b0;
    always #5 tb_clk = ~tb_clk;

    int errors = 0, checks = 0;
    logic [31:0] exp_rd_q[$];
    logic        exp_last_q[$];
    logic [24:0] exp_pix_q[$];
    logic [31:0] exp_wa_q[$];
    logic [23:0] exp_wd_q[$];
    bit  stall_all = 0, wr_stall = 0, rand_lat = 0, dp_en = 0, req_seen = 0;
    int  lat_fixed = 1, one_lat = 0, wait_cnt = 0, cur_lat = 0;
    int  pending = 0, snap_pending = 0, pend = 0, out_idx = 0, acc_cnt = 0, wl_cnt = 0;
    logic [31:0] prev_haddr = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: event not seen or not expected", name);
    endtask

    function automatic logic [23:0] pix_at(input logic [31:0] a);
        return a[23:0] ^ 24'hA5C396 ^ {a[7:0], 16'h0000};
    endfunction

    // Expected read order from image geometry: windows row-major, pixels row-major inside.
    task automatic gen_frame();
        for (int wy = 0; wy < (IH - 2) / (WH - 2); wy++)
            for (int wx = 0; wx < (IW - 2) / (WW - 2); wx++)
                for (int r = 0; r < WH; r++)
                    for (int c = 0; c < WW; c++) begin
                        exp_rd_q.push_back(RDB + 32'(BPPB * ((wy * (WH - 2) + r) * IW + wx * (WW - 2) + c)));
                        exp_last_q.push_back((r == WH - 1) && (c == WW - 1));
                    end
    endtask

    task automatic flush();
        exp_rd_q.delete(); exp_last_q.delete(); exp_pix_q.delete();
        exp_wa_q.delete(); exp_wd_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge tb_clk) start = 1'b1;
        @(negedge tb_clk) start = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int c = 0;
        while (!done && c < limit) begin @(negedge tb_clk); c++; end
        chk(name, done, 1'b1);
    endtask

    task automatic push_one();
        int target = acc_cnt + 1;
        int c = 0;
        @(negedge tb_clk);
        res_valid = 1'b1;
        res_in = 24'($urandom);
        do begin @(negedge tb_clk); c++; end while (acc_cnt < target && c < 100);
        res_valid = 1'b0;
        if (acc_cnt < target) fail_now("push_timeout");
    endtask

    // Memory responder: answers each request after a chosen latency.
    initial begin
        hready = 1'b0; hrdata = 32'd0;
        forever begin
            @(negedge tb_clk);
            if (!n_rst) begin
                hready = 1'b0; req_seen = 0;
            end else if (hready) begin
                hready = 1'b0; req_seen = 0;
            end else if (haddr != 32'd0 && !stall_all && !(hwrite && wr_stall)) begin
                if (!req_seen) begin
                    req_seen = 1; wait_cnt = 0;
                    if (one_lat > 0) begin cur_lat = one_lat; one_lat = 0; end
                    else cur_lat = rand_lat ? int'($urandom_range(3, 0)) : lat_fixed;
                end
                if (wait_cnt >= cur_lat) begin
                    hready = 1'b1;
                    hrdata = hwrite ? 32'd0 : {8'h00, pix_at(haddr)};
                end else begin
                    wait_cnt++;
                end
            end
        end
    end

    // Datapath model: nine results per completed window when enabled.
    initial begin
        res_valid = 1'b0; res_in = 24'd0;
        forever begin
            @(negedge tb_clk);
            if (dp_en) begin
                res_valid = (pend > 0) && ($urandom_range(3, 0) != 0);
                res_in    = 24'($urandom);
            end
        end
    end

    // Edge bookkeeping: accepted results become expected writes; FIFO occupancy as seen by the master.
    always @(posedge tb_clk) begin
        if (!n_rst) begin
            pending = 0; pend = 0; out_idx = 0; snap_pending = 0;
        end else begin
            snap_pending = pending;
            if (start) out_idx = 0;
            if (res_valid && res_ready) begin
                exp_wa_q.push_back(WRB + 32'(BPPB * out_idx));
                exp_wd_q.push_back(res_in);
                out_idx++; pending++; acc_cnt++;
                if (pend > 0) pend--;
            end
            if (hwrite && hready) pending--;
            if (pix_valid && win_last && dp_en) pend += NOUT / NWIN;
        end
    end

    // Monitor: compares every bus request and pixel strobe against the scoreboard.
    initial forever begin
        @(negedge tb_clk);
        if (!n_rst) begin
            prev_haddr = 32'd0;
        end else begin
            if (prev_haddr != 32'd0 && haddr != 32'd0) chk("haddr_stable", haddr, prev_haddr);
            if (haddr != 32'd0 && prev_haddr == 32'd0) begin
                if (hwrite) begin
                    if (exp_wa_q.size() == 0) fail_now("unexpected_write");
                    else begin
                        chk("wr_addr", haddr, exp_wa_q.pop_front());
                        chk("wr_data", hwdata, {8'h00, exp_wd_q.pop_front()});
                    end
                end else begin
                    chk("write_before_read", snap_pending, 32'd0);
                    if (exp_rd_q.size() == 0) fail_now("unexpected_read");
                    else begin
                        logic [31:0] a;
                        logic        l;
                        a = exp_rd_q.pop_front();
                        l = exp_last_q.pop_front();
                        chk("rd_addr", haddr, a);
                        exp_pix_q.push_back({l, pix_at(a)});
                    end
                end
            end
            if (pix_valid) begin
                if (win_last) wl_cnt++;
                if (exp_pix_q.size() == 0) fail_now("unexpected_pix_valid");
                else begin
                    logic [24:0] e;
                    e = exp_pix_q.pop_front();
                    chk("pix_out", pix_out, e[23:0]);
                    chk("win_last", win_last, e[24]);
                end
            end
            prev_haddr = haddr;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int a0;
        n_rst = 1'b0; start = 1'b0;
        repeat (3) @(negedge tb_clk);
        chk("rst_haddr", haddr, 32'd0);       chk("rst_hwrite", hwrite, 1'b0);
        chk("rst_hwdata", hwdata, 32'd0);     chk("rst_pix_out", pix_out, 24'd0);
        chk("rst_pix_valid", pix_valid, 1'b0); chk("rst_win_last", win_last, 1'b0);
        chk("rst_res_ready", res_ready, 1'b1); chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);          chk("rst_err", err, 1'b0);
        @(negedge tb_clk) n_rst = 1'b1;

        // Frame 1: reads only, then results arrive after all reads.
        gen_frame(); wl_cnt = 0;
        pulse_start();
        chk("busy_after_start", busy, 1'b1);
        c = 0;
        while ((exp_rd_q.size() != 0 || exp_pix_q.size() != 0) && c < 2000) begin @(negedge tb_clk); c++; end
        chk("frame1_reads_drained", 32'(exp_rd_q.size() + exp_pix_q.size()), 32'd0);
        repeat (4) @(negedge tb_clk);
        chk("frame1_win_last_count", 32'(wl_cnt), 32'(NWIN));
        chk("frame1_not_done", done, 1'b0);

        // Fill the FIFO with the responder stalled; the fifth push is dropped.
        stall_all = 1;
        a0 = acc_cnt;
        for (int p = 0; p < 5; p++) begin
            @(negedge tb_clk);
            if (p == 3) chk("fifo_three_ready", res_ready, 1'b1);
            if (p == 4) chk("fifo_full_ready", res_ready, 1'b0);
            res_valid = 1'b1; res_in = 24'($urandom);
        end
        @(negedge tb_clk) res_valid = 1'b0;
        chk("fifo_accepts", 32'(acc_cnt - a0), 32'd4);
        stall_all = 0;
        for (int p = 0; p < NOUT - 4; p++) push_one();
        wait_done(3000, "frame1_done");
        chk("frame1_busy_low", busy, 1'b0);
        chk("frame1_writes_drained", 32'(exp_wa_q.size()), 32'd0);

        // Frame 2: random latency, interleaved results, first read held 10 cycles.
        gen_frame(); wl_cnt = 0; rand_lat = 1; one_lat = 10; dp_en = 1;
        pulse_start();
        chk("frame2_done_cleared", done, 1'b0);
        c = 0;
        while (haddr == 32'd0 && c < 50) begin @(negedge tb_clk); c++; end
        a0 = int'(haddr); c = 0;
        while (haddr == 32'(a0) && c < 50) begin @(negedge tb_clk); c++; end
        if (c < 10) begin errors++; $display("FAIL hold_stable: haddr held %0d cycles, required at least 10", c); end
        checks++;
        wait_done(5000, "frame2_done");
        dp_en = 0; res_valid = 1'b0;
        chk("frame2_win_last_count", 32'(wl_cnt), 32'(NWIN));
        chk("frame2_queues_drained", 32'(exp_rd_q.size() + exp_pix_q.size() + exp_wa_q.size()), 32'd0);
        chk("frame2_err", err, 1'b0);

        // Reset in the middle of a stalled write, then restart.
        gen_frame(); rand_lat = 0; wr_stall = 1; dp_en = 1;
        pulse_start();
        c = 0;
        while (!hwrite && c < 2000) begin @(negedge tb_clk); c++; end
        chk("write_seen", hwrite, 1'b1);
        repeat (2) @(negedge tb_clk);
        #2 n_rst = 1'b0;
        #1;
        chk("async_rst_hwrite", hwrite, 1'b0);
        chk("async_rst_haddr", haddr, 32'd0);
        chk("async_rst_busy", busy, 1'b0);
        dp_en = 0; res_valid = 1'b0;
        repeat (2) @(negedge tb_clk);
        flush();
        n_rst = 1'b1; wr_stall = 0;
        gen_frame(); wl_cnt = 0; dp_en = 1;
        pulse_start();
        c = 0;
        while (haddr == 32'd0 && c < 50) begin @(negedge tb_clk); c++; end
        chk("restart_first_addr", haddr, RDB);
        wait_done(5000, "frame3_done");
        dp_en = 0; res_valid = 1'b0;
        chk("frame3_win_last_count", 32'(wl_cnt), 32'(NWIN));

`ifdef AHB_TIMEOUT_EN
        // No hready at all: watchdog must end the frame with err set.
        flush(); gen_frame(); stall_all = 1;
        pulse_start();
        c = 0;
        while (haddr == 32'd0 && c < 50) begin @(negedge tb_clk); c++; end
        c = 0;
        while (!done && c < 70000) begin @(negedge tb_clk); c++; end
        chk("timeout_err", err, 1'b1);
        chk("timeout_done", done, 1'b1);
        chk("timeout_haddr_idle", haddr, 32'd0);
        if (c < 65535 || c > 65540) begin errors++; $display("FAIL timeout_cycles: got %0d required 65535..65540", c); end
        checks++;
        flush(); gen_frame(); stall_all = 0;
        pulse_start();
        chk("timeout_err_cleared", err, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
